clk_div_ctrl: RTL and testbench

Synthesizable programmable clock generator controller. It derives a divided clock (clk_out) from the system clock, with a run-time configurable period and high time (duty cycle). New settings are accepted through a valid/ready config port and applied only at a period boundary, so clk_out never glitches. It sits between the chip's config bus and the clock-generation stage, and also sequences clean start/stop of the generated clock.

---
 rtl/clk_div_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable divided-clock generator: run-time period/high-time set through a
// valid/ready config port, applied only at period boundaries, with clean start/stop.
module clk_div_ctrl #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             run,
    output logic             pending,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
    logic [CNT_W-1:0] shp_q, shp_d, shh_q, shh_d;
    logic             clk_q, clk_d, rise_q, rise_d, err_q, err_d;
    logic             pend_q, pend_d, run_q, run_d;
    logic             cfg_ok, wrap, apply;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        high_d  = high_q;
        shp_d   = shp_q;
        shh_d   = shh_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;
        apply   = 1'b0;
        cnt_inc = cnt_q + ONE;
        wrap    = (cnt_q == per_q - ONE);
        cfg_ok  = (cfg_period >= TWO) && (cfg_high != '0) && (cfg_high < cfg_period);

        // Acceptance needs pend_q == 0, so it can never collide with an apply below.
        if (cfg_valid && !pend_q) begin
            if (cfg_ok) begin
                shp_d  = cfg_period;
                shh_d  = cfg_high;
                pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                apply = pend_q;
                if (en) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                    rise_d  = 1'b1;
                end
            end
            RUN, STOP: begin
                state_d = en ? RUN : STOP;
                if (wrap) begin
                    cnt_d = '0;
                    apply = pend_q;
                    if (state_q == STOP && !en) begin
                        state_d = IDLE;
                        clk_d   = 1'b0;
                    end else begin
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (apply) begin
            per_d  = shp_q;
            high_d = shh_q;
            pend_d = 1'b0;
        end
        run_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= DEF_P;
            high_q  <= DEF_H;
            shp_q   <= DEF_P;
            shh_q   <= DEF_H;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
            shp_q   <= shp_d;
            shh_q   <= shh_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
        end
    end

    assign cfg_ready  = !pend_q;
    assign cfg_err    = err_q;
    assign clk_out    = clk_q;
    assign rise_pulse = rise_q;
    assign run        = run_q;
    assign pending    = pend_q;
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed and randomized bench for clk_div_ctrl, checked every cycle against a
// position/period reference model of the divider.
module tb_clk_div_ctrl;

    localparam int CNT_W      = 8;
    localparam int DEF_PERIOD = 4;
    localparam int DEF_HIGH   = 2;
    localparam int MAXP       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             cfg_ready, cfg_err, clk_out, rise_pulse, run, pending;
    logic [CNT_W-1:0] cnt;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .DEF_HIGH(DEF_HIGH)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(cfg_err),
        .clk_out(clk_out), .rise_pulse(rise_pulse), .run(run), .pending(pending), .cnt(cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference: "on" means a divided clock is being produced; pos is the cycle
    // index inside the current period; stop_req remembers that en was last seen low.
    int m_per, m_high, m_shp, m_shh, m_pos;
    bit m_on, m_stop_req, m_pend, m_rise, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_per = DEF_PERIOD; m_high = DEF_HIGH; m_shp = DEF_PERIOD; m_shh = DEF_HIGH;
        m_pos = 0; m_on = 0; m_stop_req = 0; m_pend = 0; m_rise = 0; m_err = 0;
    endtask

    task automatic model_step();
        int  p, h;
        bit  legal, take, old_pend;
        p = int'(cfg_period);
        h = int'(cfg_high);
        legal    = (p >= 2) && (h >= 1) && (h <= p - 1);
        take     = cfg_valid && !m_pend;
        old_pend = m_pend;
        m_err    = take && !legal;
        m_rise   = 0;
        if (!m_on) begin
            if (old_pend) begin m_per = m_shp; m_high = m_shh; m_pend = 0; end
            if (en) begin m_on = 1; m_pos = 0; m_rise = 1; m_stop_req = 0; end
        end else if (m_pos == m_per - 1) begin
            if (old_pend) begin m_per = m_shp; m_high = m_shh; m_pend = 0; end
            m_pos = 0;
            if (m_stop_req && !en) m_on = 0;
            else m_rise = 1;
            m_stop_req = !en;
        end else begin
            m_pos++;
            m_stop_req = !en;
        end
        if (take && legal) begin m_shp = p; m_shh = h; m_pend = 1; end
    endtask

    task automatic check_all();
        chk("clk_out",    32'(clk_out),    32'(m_on && (m_pos < m_high)));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("run",        32'(run),        32'(m_on));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("cfg_ready",  32'(cfg_ready),  32'(!m_pend));
        chk("cfg_err",    32'(cfg_err),    32'(m_err));
        chk("cnt",        32'(cnt),        m_on ? 32'(m_pos) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_pos(input int p);
        int i;
        i = 0;
        while (!(m_on && m_pos == p) && i < 600) begin
            tick();
            i++;
        end
        if (!(m_on && m_pos == p)) begin
            total++;
            $error("FAIL wait_pos observed=timeout expected=pos %0d", p);
        end
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        int p;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();

        // Default 4/2 waveform
        en = 1'b1;
        repeat (12) tick();

        // Reconfigure to 5/1 mid-period
        wait_pos(1);
        offer(5, 1);
        repeat (14) tick();

        // Illegal requests
        offer(3, 3); tick();
        offer(1, 0); tick();
        offer(8, 0);
        repeat (6) tick();

        // Back to 4/2, then stop and stop-then-resume
        offer(4, 2);
        repeat (12) tick();
        wait_pos(1);
        en = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        wait_pos(1);
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        repeat (8) tick();

        // Config while idle, then clk/2
        offer(2, 1);
        repeat (3) tick();
        en = 1'b1;
        repeat (8) tick();

        // Asynchronous reset during the high phase
        wait_pos(0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_run",     32'(run),     32'd0);
        chk("rst_rise",    32'(rise_pulse), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        repeat (12) tick();

        // Maximum period with a single low cycle
        offer(MAXP, MAXP - 1);
        repeat (2 * MAXP + 10) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 19) == 0) ? MAXP - int'($urandom_range(0, 1))
                                             : int'($urandom_range(0, 12));
            cfg_period = CNT_W'(p);
            cfg_high   = CNT_W'($urandom_range(0, p + 1));
            tick();
        end
        cfg_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
